// File: rtl/cgra_clk_gate_ctrl.sv
// Clock-gate enable sequencer for the CGRA domain: gates after an idle hysteresis,
// re-enables on demand and acknowledges once the settle window has elapsed.
module cgra_clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             gate_allow_i,
    input  logic             req_i,
    input  logic             busy_i,
    input  logic             clr_cnt_i,
    output logic             clk_en_o,
    output logic             ack_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] gated_cycles_o
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WAKE_W-1:0] wake_cnt;
    logic              act;

    assign act     = req_i | busy_i;
    assign state_o = state;

    // clk_en_o and ack_o are registered alongside the state so the gating cell
    // never sees a combinational path from the request/busy inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= OFF;
            clk_en_o <= 1'b0;
            ack_o    <= 1'b0;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            case (state)
                OFF: begin
                    if (act || !gate_allow_i) begin
                        state    <= WAKE;
                        clk_en_o <= 1'b1;
                        wake_cnt <= '0;
                    end
                end
                WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state <= ON;
                        ack_o <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + WAKE_W'(1);
                    end
                end
                ON: begin
                    if (!act && gate_allow_i) begin
                        state    <= IDLE;
                        idle_cnt <= '0;
                    end
                end
                IDLE: begin
                    // Activity beats terminal count, so a late request never sees a dropout.
                    if (act) begin
                        state <= ON;
                    end else if (gate_allow_i) begin
                        if (idle_cnt == IDLE_LAST) begin
                            state    <= OFF;
                            clk_en_o <= 1'b0;
                            ack_o    <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= OFF;
                    clk_en_o <= 1'b0;
                    ack_o    <= 1'b0;
                end
            endcase
        end
    end

    // Counts cycles whose state register reads OFF, so the entry cycle itself is seen one edge later.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            gated_cycles_o <= '0;
        end else if (state == OFF && gated_cycles_o != {CNT_W{1'b1}}) begin
            gated_cycles_o <= gated_cycles_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cgra_clk_gate_ctrl.sv
// Directed bench for cgra_clk_gate_ctrl: a default build plus a CNT_W=4 build for saturation.
module tb_cgra_clk_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gate_allow = 1'b1;
    logic        req = 1'b0;
    logic        busy = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        clk_en, ack;
    logic [1:0]  state;
    logic [31:0] gated;
    logic        clk_en4, ack4;
    logic [1:0]  state4;
    logic [3:0]  gated4;

    int checks = 0;
    int passes = 0;

    cgra_clk_gate_ctrl dut (
        .clk_i(clk), .rst_i(rst), .gate_allow_i(gate_allow), .req_i(req),
        .busy_i(busy), .clr_cnt_i(clr_cnt), .clk_en_o(clk_en), .ack_o(ack),
        .state_o(state), .gated_cycles_o(gated)
    );

    cgra_clk_gate_ctrl #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .gate_allow_i(gate_allow), .req_i(req),
        .busy_i(busy), .clr_cnt_i(clr_cnt), .clk_en_o(clk_en4), .ack_o(ack4),
        .state_o(state4), .gated_cycles_o(gated4)
    );

    always #5 clk = ~clk;

    // Inputs set before a call are sampled at this edge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state); else passes++;
        checks++; if (clk_en !== 1'b0 || ack !== 1'b0) $display("[TB] FAIL reset_outputs: clk_en=%0b ack=%0b expected 0 0", clk_en, ack); else passes++;
        checks++; if (gated !== 32'd0) $display("[TB] FAIL reset_count: got %0d expected 0", gated); else passes++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (clk_en !== 1'b0 || ack !== 1'b0) $display("[TB] FAIL off_hold cycle %0d: clk_en=%0b ack=%0b expected 0 0", i, clk_en, ack);
            else passes++;
        end
        checks++; if (gated !== 32'd10) $display("[TB] FAIL off_count: got %0d expected 10", gated); else passes++;
        checks++; if (gated4 !== 4'd10) $display("[TB] FAIL off_count4: got %0d expected 10", gated4); else passes++;
    endtask

    task automatic test_wake_and_gate();
        req = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1 || ack !== 1'b0 || state !== 2'd1) $display("[TB] FAIL wake_n: clk_en=%0b ack=%0b state=%0d expected 1 0 1", clk_en, ack, state); else passes++;
        req = 1'b0;
        step();
        checks++; if (ack !== 1'b0 || state !== 2'd1) $display("[TB] FAIL wake_n1: ack=%0b state=%0d expected 0 1", ack, state); else passes++;
        step();
        checks++; if (ack !== 1'b1 || state !== 2'd2) $display("[TB] FAIL wake_ack: ack=%0b state=%0d expected 1 2", ack, state); else passes++;
        checks++; if (gated !== 32'd11) $display("[TB] FAIL wake_count: got %0d expected 11", gated); else passes++;
        step();
        checks++; if (state !== 2'd3) $display("[TB] FAIL enter_idle: state=%0d expected 3", state); else passes++;
        for (int k = 4; k < 19; k++) begin
            step();
            checks++;
            if (clk_en !== 1'b1 || ack !== 1'b1) $display("[TB] FAIL idle_hyst n+%0d: clk_en=%0b ack=%0b expected 1 1", k, clk_en, ack);
            else passes++;
        end
        step();
        checks++; if (clk_en !== 1'b0 || ack !== 1'b0 || state !== 2'd0) $display("[TB] FAIL gate_n19: clk_en=%0b ack=%0b state=%0d expected 0 0 0", clk_en, ack, state); else passes++;
        checks++; if (gated !== 32'd11) $display("[TB] FAIL gate_entry_count: got %0d expected 11", gated); else passes++;
    endtask

    task automatic test_busy_at_terminal();
        int drops;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        step();
        checks++; if (state !== 2'd3) $display("[TB] FAIL term_idle_entry: state=%0d expected 3", state); else passes++;
        drops = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (clk_en !== 1'b1) drops++;
        end
        checks++; if (drops != 0 || state !== 2'd3) $display("[TB] FAIL term_pre: drops=%0d state=%0d expected 0 3", drops, state); else passes++;
        busy = 1'b1;
        step();
        checks++; if (state !== 2'd2 || clk_en !== 1'b1) $display("[TB] FAIL term_busy: state=%0d clk_en=%0b expected 2 1", state, clk_en); else passes++;
        checks++; if (gated !== 32'd12) $display("[TB] FAIL term_count: got %0d expected 12", gated); else passes++;
        busy = 1'b0;
    endtask

    task automatic test_gate_allow_low();
        int bad;
        step();
        for (int i = 0; i < 16; i++) step();
        checks++; if (state !== 2'd0) $display("[TB] FAIL ga_off: state=%0d expected 0", state); else passes++;
        gate_allow = 1'b0;
        step();
        checks++; if (state !== 2'd1 || clk_en !== 1'b1) $display("[TB] FAIL ga_wake: state=%0d clk_en=%0b expected 1 1", state, clk_en); else passes++;
        step();
        step();
        checks++; if (state !== 2'd2 || ack !== 1'b1) $display("[TB] FAIL ga_on: state=%0d ack=%0b expected 2 1", state, ack); else passes++;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (clk_en !== 1'b1 || state !== 2'd2) bad++;
        end
        checks++; if (bad != 0) $display("[TB] FAIL ga_forced_on: bad cycles=%0d expected 0", bad); else passes++;
        gate_allow = 1'b1;
        step();
        checks++; if (state !== 2'd3) $display("[TB] FAIL ga_idle: state=%0d expected 3", state); else passes++;
        for (int i = 0; i < 15; i++) step();
        checks++; if (clk_en !== 1'b1) $display("[TB] FAIL ga_idle15: clk_en=%0b expected 1", clk_en); else passes++;
        step();
        checks++; if (state !== 2'd0 || clk_en !== 1'b0) $display("[TB] FAIL ga_off16: state=%0d clk_en=%0b expected 0 0", state, clk_en); else passes++;
        checks++; if (gated !== 32'd13) $display("[TB] FAIL ga_count: got %0d expected 13", gated); else passes++;
    endtask

    task automatic test_idle_hold();
        int bad;
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) step();
        gate_allow = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (state !== 2'd3 || clk_en !== 1'b1) bad++;
        end
        checks++; if (bad != 0) $display("[TB] FAIL hold_idle: bad cycles=%0d expected 0", bad); else passes++;
        gate_allow = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++; if (state !== 2'd3) $display("[TB] FAIL hold_resume: state=%0d expected 3", state); else passes++;
        step();
        checks++; if (state !== 2'd0) $display("[TB] FAIL hold_gate: state=%0d expected 0", state); else passes++;
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gated4 !== 4'd15) bad++;
        end
        checks++; if (bad != 0) $display("[TB] FAIL sat_hold: cycles not at 15=%0d expected 0", bad); else passes++;
        checks++; if (gated !== 32'd34) $display("[TB] FAIL sat_wide: got %0d expected 34", gated); else passes++;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++; if (gated4 !== 4'd0 || gated !== 32'd0) $display("[TB] FAIL clr: gated4=%0d gated=%0d expected 0 0", gated4, gated); else passes++;
        step();
        checks++; if (gated4 !== 4'd1) $display("[TB] FAIL clr_resume1: got %0d expected 1", gated4); else passes++;
        step();
        checks++; if (gated4 !== 4'd2) $display("[TB] FAIL clr_resume2: got %0d expected 2", gated4); else passes++;
    endtask

    task automatic test_reset_mid();
        req = 1'b1;
        step();
        checks++; if (state !== 2'd1) $display("[TB] FAIL rw_pre: state=%0d expected 1", state); else passes++;
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (state !== 2'd0 || clk_en !== 1'b0 || ack !== 1'b0 || gated !== 32'd0) $display("[TB] FAIL rst_wake: state=%0d clk_en=%0b ack=%0b gated=%0d expected 0 0 0 0", state, clk_en, ack, gated); else passes++;
        req = 1'b1;
        step();
        req = 1'b0;
        checks++; if (clk_en !== 1'b1 || ack !== 1'b0) $display("[TB] FAIL rw_wake0: clk_en=%0b ack=%0b expected 1 0", clk_en, ack); else passes++;
        step();
        checks++; if (ack !== 1'b0) $display("[TB] FAIL rw_wake1: ack=%0b expected 0", ack); else passes++;
        step();
        checks++; if (ack !== 1'b1) $display("[TB] FAIL rw_wake2: ack=%0b expected 1", ack); else passes++;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++; if (state !== 2'd3) $display("[TB] FAIL ri_pre: state=%0d expected 3", state); else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (state !== 2'd0 || clk_en !== 1'b0 || ack !== 1'b0 || gated !== 32'd0) $display("[TB] FAIL rst_idle: state=%0d clk_en=%0b ack=%0b gated=%0d expected 0 0 0 0", state, clk_en, ack, gated); else passes++;
        req = 1'b1;
        step();
        req = 1'b0;
        checks++; if (clk_en !== 1'b1 || ack !== 1'b0) $display("[TB] FAIL ri_wake0: clk_en=%0b ack=%0b expected 1 0", clk_en, ack); else passes++;
        step();
        checks++; if (ack !== 1'b0) $display("[TB] FAIL ri_wake1: ack=%0b expected 0", ack); else passes++;
        step();
        checks++; if (ack !== 1'b1 || state !== 2'd2) $display("[TB] FAIL ri_wake2: ack=%0b state=%0d expected 1 2", ack, state); else passes++;
    endtask

    initial begin
        test_reset();
        test_wake_and_gate();
        test_busy_at_terminal();
        test_gate_allow_low();
        test_idle_hold();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cgra_clk_gate_ctrl.md
# cgra_clk_gate_ctrl

Sequencer that drives the enable input of the CGRA clock-gating cell. It tracks CGRA activity (work requests and busy status) and gates the CGRA clock after a programmable idle hysteresis. It re-enables the clock on demand and acknowledges only after a settle window, so the requester knows the gated domain is running. It sits in the always-on domain next to the clock gate and counts gated cycles for power bookkeeping.

## Interface
Parameters:
- IDLE_CYCLES, default 16: consecutive inactive cycles in IDLE before gating; legal range ≥1.
- WAKE_CYCLES, default 2: settle cycles with the clock enabled before ack; legal range ≥1.
- CNT_W, default 32: width of the gated-cycle counter.

Ports:
- clk_i  in  1  ungated source clock, the same clock that feeds the gating cell.
- rst_i  in  1  reset; synchronous, active-high.
- gate_allow_i  in  1  1 = gating permitted; 0 = clock forced on.
- req_i  in  1  level work request from the bus/DMA side.
- busy_i  in  1  CGRA busy status, synchronous to clk_i.
- clr_cnt_i  in  1  single-cycle pulse that clears gated_cycles_o.
- clk_en_o  out  1  drives the en_i input of the clock-gating cell.
- ack_o  out  1  1 = CGRA clock running and settled.
- state_o  out  2  encoding: OFF=0, WAKE=1, ON=2, IDLE=3.
- gated_cycles_o  out  CNT_W  count of cycles spent in OFF; saturating.

## Operation
- Moore FSM with states OFF, WAKE, ON, IDLE. Every output is decoded from registers only, with no combinational input-to-output path.
- Activity: act = req_i | busy_i.
- OFF:
  - clk_en_o=0, ack_o=0.
  - Moves to WAKE when act=1 or gate_allow_i=0.
- WAKE:
  - clk_en_o=1, ack_o=0.
  - Wake counter loads 0 on entry and increments each cycle.
  - Moves to ON at the edge where the counter equals WAKE_CYCLES-1.
  - Inputs are ignored during WAKE; it always completes.
- ON:
  - clk_en_o=1, ack_o=1.
  - Moves to IDLE when act=0 and gate_allow_i=1. The idle counter loads 0 on this transition.
- IDLE:
  - clk_en_o=1, ack_o=1.
  - If act=1, moves to ON. Activity has priority over terminal count.
  - Else if gate_allow_i=0, stays in IDLE and holds the idle counter.
  - Else if the idle counter equals IDLE_CYCLES-1, moves to OFF.
  - Otherwise the idle counter increments.
- gated_cycles_o:
  - Increments in every cycle where state=OFF.
  - Saturates at 2^CNT_W-1.
  - clr_cnt_i forces 0 and takes priority over increment.
- Counter widths: idle counter is $clog2(IDLE_CYCLES+1) bits; wake counter is $clog2(WAKE_CYCLES+1) bits. Neither may wrap.

## Timing
- Reset, applied at any edge including mid-WAKE or mid-IDLE:
  - state=OFF, clk_en_o=0, ack_o=0, state_o=0, gated_cycles_o=0.
  - Wake and idle counters = 0.
- Cycle numbering: inputs sampled at edge n give outputs valid in cycle n.
- Wake latency:
  - act rises and is sampled at edge n while in OFF.
  - clk_en_o=1 in cycle n.
  - ack_o=1 in cycle n+WAKE_CYCLES.
- Gate latency:
  - act=0 first sampled in ON at edge m.
  - IDLE from cycle m; clk_en_o=0 from cycle m+IDLE_CYCLES, provided act stays 0 and gate_allow_i stays 1.
  - ack_o falls in the same cycle as clk_en_o.
- act=1 sampled at the terminal-count edge of IDLE: goes to ON, clk_en_o never drops.
- gate_allow_i falling in OFF: WAKE on the next edge; ack after WAKE_CYCLES as normal.
- req_i dropping during WAKE: WAKE still completes to ON, then ON→IDLE per the normal rule.
- The gated-cycle counter increments first in the cycle after the OFF entry edge, i.e. in the first OFF cycle it reads its previous value.

## Test plan
- Reset, then hold req_i=0, busy_i=0, gate_allow_i=1 for 10 cycles:
  - clk_en_o=0 and ack_o=0 throughout.
  - gated_cycles_o=10 (after reset it counts every OFF cycle).
- Defaults (WAKE_CYCLES=2, IDLE_CYCLES=16). Pulse req_i for one cycle sampled at edge n:
  - clk_en_o=1 at n, ack_o=1 at n+2, state_o=2.
  - With no further activity: IDLE at n+3, clk_en_o=0 at n+19.
- In IDLE, assert busy_i exactly at the terminal-count edge (16th IDLE cycle):
  - State goes to ON, clk_en_o stays 1 with no glitch cycle.
  - gated_cycles_o unchanged.
- Drive gate_allow_i=0 while in OFF:
  - WAKE next edge, ON two edges later.
  - Stays ON/IDLE with clk_en_o=1 for 100 idle cycles.
  - Re-assert gate_allow_i=1: OFF exactly 16 cycles later.
- Preload the counter near saturation (CNT_W=4 build), stay in OFF for 20 cycles:
  - gated_cycles_o holds at 15.
  - clr_cnt_i in an OFF cycle gives 0 next cycle, then it resumes counting.
- Assert rst_i mid-WAKE and mid-IDLE:
  - Next cycle state_o=0, clk_en_o=0, ack_o=0, gated_cycles_o=0.
  - A subsequent req_i wakes with the full WAKE_CYCLES latency.
